// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared definitions for the EX-stage iterative multiply/divide
// unit.
//   - op_e     : decoded MULT/MULTU/DIV/DIVU encodings as carried on the 2-bit op bus
//   - state_e  : sequencer states
//   - cnt_w()  : iteration counter width for a given operand width
package ex_muldiv_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // The counter must hold 0..w-1; guard against w==1 giving a zero width.
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_w(MD_WIDTH);

endpackage

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: request/response bundle between the ID/EX register and the
// multiply/divide unit.
//   start, op, rs_val, rt_val, flush : issued by the pipeline (master)
//   stall, busy, done, div_by_zero   : unit status back to the pipeline
//   hi, lo                           : architectural HI/LO registers
interface ex_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val, flush,
        input  stall, busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, flush,
        output stall, busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative radix-2 multiply / restoring divide unit for the EX stage.
// One shared 2*WIDTH accumulator serves both operations; operands are reduced
// to magnitudes on entry and the result sign is restored in a single FIX cycle.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - ex_muldiv_if.slave: start/op/rs_val/rt_val/flush in,
//          stall/busy/done/div_by_zero/hi/lo out
// Latency: start sampled at edge T -> done in cycle T+WIDTH+2.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    ex_muldiv_if.slave  bus
);

    localparam int CW = cnt_w(WIDTH);

    function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] x, input logic en);
        return en ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] x, input logic en);
        return en ? (~x + 1'b1) : x;
    endfunction

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;      // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   opnd_q;     // mul: multiplicand magnitude; div: divisor magnitude
    logic               is_div_q;
    logic               neg_q;      // product/quotient must be negated in FIX
    logic               rneg_q;     // remainder takes the dividend's negative sign
    logic               dbz_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    // Operand decode on the issue cycle
    logic               in_signed, in_div, a_neg, b_neg, accept;
    logic [WIDTH-1:0]   mag_a, mag_b;

    assign in_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign in_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign a_neg     = in_signed & bus.rs_val[WIDTH-1];
    assign b_neg     = in_signed & bus.rt_val[WIDTH-1];
    assign mag_a     = cneg_w(bus.rs_val, a_neg);
    assign mag_b     = cneg_w(bus.rt_val, b_neg);
    assign accept    = bus.start & ~bus.flush;

    // Multiply step: add into the upper half, then shift right keeping the carry.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                               : {1'b0, acc_q[2*WIDTH-1:1]};

    // Divide step: the shifted remainder is the top WIDTH+1 accumulator bits.
    // If its MSB is set it already exceeds any divisor, so the trial result is
    // non-negative regardless of the subtractor's borrow bit.
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;

    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_ge    = div_shift[WIDTH] | ~div_diff[WIDTH];
    assign div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], div_ge};

    // Sign fix-up of the finished magnitudes
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, hi_d, lo_d;

    assign prod_fix = cneg_2w(acc_q, neg_q);
    assign quo_fix  = cneg_w(acc_q[WIDTH-1:0], neg_q);
    assign rem_fix  = cneg_w(acc_q[2*WIDTH-1:WIDTH], rneg_q);
    assign hi_d     = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign lo_d     = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN: begin
                if (bus.flush)                      state_d = IDLE;
                else if (cnt_q == CW'(WIDTH - 1))   state_d = FIX;
            end
            FIX:  state_d = bus.flush ? IDLE : DONE;
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        cnt_q    <= '0;
                        is_div_q <= in_div;
                        neg_q    <= a_neg ^ b_neg;
                        rneg_q   <= a_neg;
                        dbz_q    <= in_div && (bus.rt_val == '0);
                        opnd_q   <= in_div ? mag_b : mag_a;
                        acc_q    <= {{WIDTH{1'b0}}, (in_div ? mag_a : mag_b)};
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    acc_q <= is_div_q ? div_next : mul_next;
                end
                FIX: begin
                    if (!bus.flush) begin
                        hi_q <= hi_d;
                        lo_q <= lo_d;
                    end
                end
                DONE: ;
            endcase
        end
    end

    assign bus.stall       = (state_q == RUN) || (state_q == FIX);
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE) && !bus.flush;
    assign bus.div_by_zero = bus.done && dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    ex_muldiv_if #(.WIDTH(32)) bus ();

    ex_muldiv #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op and wait for done; lat counts cycles after the sampling edge.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int serr);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.rs_val = a;
        bus.rt_val = b;
        lat  = 0;
        serr = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) bus.start = 1'b0;
            if (bus.stall !== ((lat >= 1 && lat <= 33) ? 1'b1 : 1'b0)) serr++;
            if (bus.done === 1'b1) break;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.hi, bus.lo} !== 64'd0) begin
            $display("FAIL reset_hilo: got %h_%h expected 0", bus.hi, bus.lo); n_fail++;
        end
        n_checks++;
        if ({bus.stall, bus.busy, bus.done, bus.div_by_zero} !== 4'b0000) begin
            $display("FAIL reset_ctrl: got %b expected 0000",
                     {bus.stall, bus.busy, bus.done, bus.div_by_zero}); n_fail++;
        end
        rst = 1'b0;
    endtask

    task automatic test_multu_max;
        int lat, serr;
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, serr);
        n_checks++;
        if (lat !== 34) begin $display("FAIL multu_latency: got %0d expected 34", lat); n_fail++; end
        n_checks++;
        if (serr !== 0) begin $display("FAIL multu_stall: got %0d bad cycles expected 0", serr); n_fail++; end
        n_checks++;
        if (bus.hi !== 32'hFFFF_FFFE) begin $display("FAIL multu_hi: got %h expected fffffffe", bus.hi); n_fail++; end
        n_checks++;
        if (bus.lo !== 32'h0000_0001) begin $display("FAIL multu_lo: got %h expected 00000001", bus.lo); n_fail++; end
        @(negedge clk);
        n_checks++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            $display("FAIL multu_after: got done,busy=%b expected 00", {bus.done, bus.busy}); n_fail++;
        end
    endtask

    task automatic test_mult_signed;
        int lat, serr;
        run_op(2'd0, 32'hFFFF_FFFD, 32'd5, lat, serr);
        n_checks++;
        if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
            $display("FAIL mult_signed: got %h_%h expected ffffffff_fffffff1", bus.hi, bus.lo); n_fail++;
        end
        n_checks++;
        if (bus.div_by_zero !== 1'b0) begin $display("FAIL mult_dbz: got %b expected 0", bus.div_by_zero); n_fail++; end
    endtask

    task automatic test_divide;
        int lat, serr;
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, lat, serr);
        n_checks++;
        if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            $display("FAIL div_signed: got %h_%h expected ffffffff_fffffffd", bus.hi, bus.lo); n_fail++;
        end
        run_op(2'd3, 32'd7, 32'd2, lat, serr);
        n_checks++;
        if (lat !== 34) begin $display("FAIL divu_latency: got %0d expected 34", lat); n_fail++; end
        n_checks++;
        if ({bus.hi, bus.lo} !== 64'h0000_0001_0000_0003) begin
            $display("FAIL divu: got %h_%h expected 00000001_00000003", bus.hi, bus.lo); n_fail++;
        end
    endtask

    task automatic test_div_zero;
        int lat, serr;
        run_op(2'd3, 32'h64, 32'd0, lat, serr);
        n_checks++;
        if (bus.div_by_zero !== 1'b1) begin $display("FAIL dbz_flag: got %b expected 1", bus.div_by_zero); n_fail++; end
        n_checks++;
        if ({bus.hi, bus.lo} !== 64'h0000_0064_FFFF_FFFF) begin
            $display("FAIL dbz_result: got %h_%h expected 00000064_ffffffff", bus.hi, bus.lo); n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if (bus.div_by_zero !== 1'b0) begin $display("FAIL dbz_pulse: got %b expected 0", bus.div_by_zero); n_fail++; end
    endtask

    task automatic test_overflow;
        int lat, serr;
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, serr);
        n_checks++;
        if ({bus.hi, bus.lo} !== 64'h0000_0000_8000_0000) begin
            $display("FAIL div_ovf: got %h_%h expected 00000000_80000000", bus.hi, bus.lo); n_fail++;
        end
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, lat, serr);
        n_checks++;
        if ({bus.hi, bus.lo} !== 64'h4000_0000_0000_0000) begin
            $display("FAIL mult_ovf: got %h_%h expected 40000000_00000000", bus.hi, bus.lo); n_fail++;
        end
    endtask

    task automatic test_flush;
        int lat, serr, ndone;
        run_op(2'd3, 32'd7, 32'd2, lat, serr);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = 2'd1;
        bus.rs_val = 32'd2;
        bus.rt_val = 32'd2;
        for (int l = 1; l <= 10; l++) begin
            @(negedge clk);
            if (l == 1)  bus.start = 1'b0;
            if (l == 10) bus.flush = 1'b1;
        end
        @(negedge clk);
        bus.flush = 1'b0;
        n_checks++;
        if ({bus.stall, bus.busy} !== 2'b00) begin
            $display("FAIL flush_idle: got stall,busy=%b expected 00", {bus.stall, bus.busy}); n_fail++;
        end
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done !== 1'b0) ndone++;
        end
        n_checks++;
        if (ndone !== 0) begin $display("FAIL flush_done: got %0d done cycles expected 0", ndone); n_fail++; end
        n_checks++;
        if ({bus.hi, bus.lo} !== 64'h0000_0001_0000_0003) begin
            $display("FAIL flush_hold: got %h_%h expected 00000001_00000003", bus.hi, bus.lo); n_fail++;
        end
        // start qualified by flush in IDLE must not launch an op
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0) begin $display("FAIL flush_start: got busy=%b expected 0", bus.busy); n_fail++; end
    endtask

    task automatic test_reset_mid;
        int lat, serr;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = 2'd2;
        bus.rs_val = 32'd100;
        bus.rt_val = 32'd7;
        for (int l = 1; l <= 20; l++) begin
            @(negedge clk);
            if (l == 1)  bus.start = 1'b0;
            if (l == 20) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({bus.stall, bus.busy, bus.done, bus.div_by_zero} !== 4'b0000 || {bus.hi, bus.lo} !== 64'd0) begin
            $display("FAIL reset_mid: got ctrl=%b hi=%h lo=%h expected all 0",
                     {bus.stall, bus.busy, bus.done, bus.div_by_zero}, bus.hi, bus.lo); n_fail++;
        end
        run_op(2'd3, 32'h64, 32'd7, lat, serr);
        n_checks++;
        if (lat !== 34 || {bus.hi, bus.lo} !== 64'h0000_0002_0000_000E) begin
            $display("FAIL reset_rerun: got lat=%0d %h_%h expected 34 00000002_0000000e",
                     lat, bus.hi, bus.lo); n_fail++;
        end
    endtask

    task automatic test_start_ignored;
        int lat;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = 2'd1;
        bus.rs_val = 32'd3;
        bus.rt_val = 32'd4;
        lat = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            lat++;
            bus.start = 1'b0;
            if (lat == 5) begin
                bus.start  = 1'b1;
                bus.op     = 2'd3;
                bus.rs_val = 32'd9;
                bus.rt_val = 32'd0;
            end
            if (bus.done === 1'b1) break;
        end
        bus.start = 1'b0;
        n_checks++;
        if (lat !== 34 || {bus.hi, bus.lo} !== 64'h0000_0000_0000_000C || bus.div_by_zero !== 1'b0) begin
            $display("FAIL start_busy: got lat=%0d %h_%h dbz=%b expected 34 00000000_0000000c 0",
                     lat, bus.hi, bus.lo, bus.div_by_zero); n_fail++;
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.op     = 2'd0;
        bus.rs_val = '0;
        bus.rt_val = '0;
        test_reset();
        test_multu_max();
        test_mult_signed();
        test_divide();
        test_div_zero();
        test_overflow();
        test_flush();
        test_reset_mid();
        test_start_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
